// File: rtl/nerv_bus_pkg.sv
// Shared types and default widths for the NERV Wishbone arbiter.
package nerv_bus_pkg;

  localparam int unsigned DefAddrWidth     = 32;
  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefTimeoutCycles = 255;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  typedef enum logic {
    GrantInstr,
    GrantData
  } grant_e;

endpackage

// File: rtl/nerv_wb_arbiter.sv
// Two-port (instruction/data) to single pipelined Wishbone master arbiter.
// Data port has fixed priority; one transaction in flight, guarded by a timeout.
module nerv_wb_arbiter
  import nerv_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  // Instruction port
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ack,
  output logic                    i_err,
  // Data port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_sel,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  // Wishbone master
  output logic                    core_cyc,
  output logic                    core_stb,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_sel,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic [DATA_WIDTH-1:0]   core_data_out,
  input  logic [DATA_WIDTH-1:0]   core_data_in,
  input  logic                    core_ack
);

  localparam int unsigned SelWidth = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  grant_e                grant_q, grant_d;
  logic                  err_q, err_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth:0]     cnt_inc;
  logic                  timeout;
  logic                  we_q, we_d;
  logic [SelWidth-1:0]   sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Next-state: arbitration, bus phase sequencing, timeout and read-data capture.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // Count including the current cycle; timeout fires when it reaches the limit.
    cnt_inc   = {1'b0, cnt_q} + (CntWidth + 1)'(1);
    timeout   = (cnt_inc >= (CntWidth + 1)'(TIMEOUT_CYCLES));

    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          grant_d = GrantData;
          we_d    = d_we;
          sel_d   = d_sel;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          cnt_d   = '0;
          state_d = StIssue;
        end else if (i_req) begin
          grant_d = GrantInstr;
          we_d    = 1'b0;
          sel_d   = '1;
          addr_d  = i_addr;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        // Never exceeds TIMEOUT_CYCLES since the state is left when it is reached.
        cnt_d = cnt_inc[CntWidth-1:0];
        // Ack beats a coincident timeout.
        if (core_ack) begin
          err_d   = 1'b0;
          state_d = StResp;
          if (grant_q == GrantData) d_rdata_d = core_data_in;
          else                      i_rdata_d = core_data_in;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StResp;
          if (grant_q == GrantData) d_rdata_d = '0;
          else                      i_rdata_d = '0;
        end else begin
          state_d = StWait;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q   <= StIdle;
      grant_q   <= GrantInstr;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign core_cyc      = (state_q == StIssue) || (state_q == StWait);
  assign core_stb      = (state_q == StIssue);
  assign core_we       = we_q;
  assign core_sel      = sel_q;
  assign core_addr     = addr_q;
  assign core_data_out = wdata_q;

  assign i_ack   = (state_q == StResp) && (grant_q == GrantInstr) && !err_q;
  assign i_err   = (state_q == StResp) && (grant_q == GrantInstr) &&  err_q;
  assign d_ack   = (state_q == StResp) && (grant_q == GrantData)  && !err_q;
  assign d_err   = (state_q == StResp) && (grant_q == GrantData)  &&  err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
